// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler: two-way signal phase sequencer with pedestrian walk arbitration; define EMERG_PREEMPT_EN for emergency preemption
module intersection_phase_scheduler #(
  parameter int GREEN_TICKS  = 20,
  parameter int YELLOW_TICKS = 4,
  parameter int ALLRED_TICKS = 2,
  parameter int PED_TICKS    = 10,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [1:0]       ped_req,
  input  logic             emerg_req,
  input  logic             emerg_dir,
  output logic [1:0]       ns_light,
  output logic [1:0]       ew_light,
  output logic [1:0]       ped_walk,
  output logic [1:0]       ped_ack,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] time_left
);
  typedef enum logic [2:0] {NS_G, NS_Y, AR_1, EW_G, EW_Y, AR_2} phase_t;
  phase_t st, st_n, succ, tgt;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0] pend, walk_en, grant;
  logic legal, adv, hold, preempt, emerg;
  function automatic logic [CNT_W-1:0] dur_m1(input phase_t p);
    return (p == NS_G || p == EW_G) ? CNT_W'(GREEN_TICKS - 1) :
           (p == NS_Y || p == EW_Y) ? CNT_W'(YELLOW_TICKS - 1) : CNT_W'(ALLRED_TICKS - 1);
  endfunction
`ifdef EMERG_PREEMPT_EN
  assign emerg = emerg_req;
`else
  logic emerg_unused;
  assign emerg_unused = emerg_req;
  assign emerg = 1'b0;
`endif
  always_comb begin
    legal   = st <= AR_2;
    succ    = st == AR_2 ? NS_G : phase_t'(st + 3'd1);
    tgt     = emerg && (st == AR_1 || st == AR_2) ? (emerg_dir ? EW_G : NS_G) : succ;
    preempt = emerg && st == (emerg_dir ? NS_G : EW_G);
    hold    = emerg && st == (emerg_dir ? EW_G : NS_G);
    adv     = legal && !preempt && !hold && tick && cnt == '0;
    st_n    = !legal ? AR_2 : preempt ? (emerg_dir ? NS_Y : EW_Y) : adv ? tgt : st;
    cnt_n   = (!legal || preempt || adv) ? dur_m1(st_n) : (tick && !hold) ? cnt - CNT_W'(1) : cnt;
    grant   = {adv && st_n == EW_G, adv && st_n == NS_G} & (pend | ped_req) & {2{!emerg}};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st      <= AR_2;
      cnt     <= CNT_W'(ALLRED_TICKS - 1);
      pend    <= '0;
      walk_en <= '0;
      ped_ack <= '0;
    end else begin
      st      <= st_n;
      cnt     <= cnt_n;
      pend    <= (pend | ped_req) & ~grant;
      walk_en <= preempt ? 2'b00 : adv ? grant : walk_en;
      ped_ack <= grant;
    end
  end
  assign phase     = st;
  assign time_left = cnt;
  assign ns_light  = st == NS_G ? 2'b10 : st == NS_Y ? 2'b01 : 2'b00;
  assign ew_light  = st == EW_G ? 2'b10 : st == EW_Y ? 2'b01 : 2'b00;
  assign ped_walk  = walk_en & {st == EW_G, st == NS_G} &
                     {2{cnt >= CNT_W'(GREEN_TICKS - PED_TICKS) && !hold}};
endmodule
